// File: rtl/emulib_dma_burst_writer_pkg.sv
// Shared AXI encodings and state type for the checkpoint DMA burst writer.
package emulib_dma_burst_writer_pkg;

  localparam logic [1:0]  BURST_INCR  = 2'b01;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam int unsigned BOUNDARY_4K = 4096;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_COUNT,
    ST_CALC,
    ST_AW,
    ST_W,
    ST_B
  } state_t;

endpackage

// File: rtl/emulib_dma_burst_len.sv
// Burst length: smallest of beats left, the burst-length cap and beats to the next 4 KiB page.
module emulib_dma_burst_len #(
  parameter int COUNT_WIDTH   = 16,
  parameter int DATA_WIDTH    = 64,
  parameter int MAX_BURST_LEN = 16
) (
  input  logic [COUNT_WIDTH-1:0] remaining,
  input  logic [11:0]            addr_low,
  output logic [8:0]             len
);
  import emulib_dma_burst_writer_pkg::*;

  localparam int SIZE = $clog2(DATA_WIDTH / 8);
  // Wide enough for both the beat count and up to 4096 beats to the boundary.
  localparam int CW   = (COUNT_WIDTH > 14) ? COUNT_WIDTH : 14;

  logic [12:0]   bytes_to_bnd;
  logic [CW-1:0] rem_w;
  logic [CW-1:0] bnd_w;
  logic [CW-1:0] max_w;
  logic [CW-1:0] min_a;
  logic [CW-1:0] min_b;

  always_comb begin
    bytes_to_bnd = 13'(BOUNDARY_4K) - {1'b0, addr_low};
    rem_w        = CW'(remaining);
    bnd_w        = CW'(bytes_to_bnd >> SIZE);
    max_w        = CW'(MAX_BURST_LEN);
    min_a        = (rem_w < max_w) ? rem_w : max_w;
    min_b        = (min_a < bnd_w) ? min_a : bnd_w;
    len          = 9'(min_b);
  end

endmodule

// File: rtl/emulib_dma_burst_writer.sv
// Write-side AXI4 INCR burst engine: splits a beat stream at the length cap and 4 KiB pages,
// one burst outstanding, with idle status and a sticky write-response error.
module emulib_dma_burst_writer #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 64,
  parameter int COUNT_WIDTH   = 16,
  parameter int MAX_BURST_LEN = 16
) (
  input  logic                    host_clk,
  input  logic                    host_rst_n,
  input  logic                    s_write_addr_valid,
  output logic                    s_write_addr_ready,
  input  logic [ADDR_WIDTH-1:0]   s_write_addr,
  input  logic                    s_write_count_valid,
  output logic                    s_write_count_ready,
  input  logic [COUNT_WIDTH-1:0]  s_write_count,
  input  logic                    s_write_data_valid,
  output logic                    s_write_data_ready,
  input  logic [DATA_WIDTH-1:0]   s_write_data,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awlock,
  output logic [3:0]              m_axi_awcache,
  output logic [2:0]              m_axi_awprot,
  output logic [3:0]              m_axi_awqos,
  output logic [3:0]              m_axi_awregion,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  input  logic                    m_axi_bvalid,
  input  logic [1:0]              m_axi_bresp,
  output logic                    m_axi_bready,
  output logic                    w_idle,
  output logic                    w_err
);
  import emulib_dma_burst_writer_pkg::*;

  localparam int SIZE   = $clog2(DATA_WIDTH / 8);
  localparam int STRB_W = DATA_WIDTH / 8;

  state_t                 state;
  state_t                 state_nxt;
  logic                   rst_done;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [COUNT_WIDTH-1:0] remaining;
  logic [8:0]             beat_cnt;
  logic [8:0]             len_q;
  logic [8:0]             len_calc;
  logic [7:0]             awlen_q;
  logic                   addr_hs;
  logic                   count_hs;
  logic                   w_hs;
  logic                   last_beat;
  logic                   b_hs;

  emulib_dma_burst_len #(
    .COUNT_WIDTH   (COUNT_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH),
    .MAX_BURST_LEN (MAX_BURST_LEN)
  ) u_len (
    .remaining (remaining),
    .addr_low  (addr_q[11:0]),
    .len       (len_calc)
  );

  assign s_write_addr_ready  = rst_done && (state == ST_IDLE);
  assign s_write_count_ready = (state == ST_WAIT_COUNT);
  assign s_write_data_ready  = (state == ST_W) && m_axi_wready;

  assign m_axi_awvalid  = (state == ST_AW);
  assign m_axi_awaddr   = addr_q;
  assign m_axi_awlen    = awlen_q;
  assign m_axi_awsize   = 3'(SIZE);
  assign m_axi_awburst  = BURST_INCR;
  assign m_axi_awlock   = 1'b0;
  assign m_axi_awcache  = 4'd0;
  assign m_axi_awprot   = 3'd0;
  assign m_axi_awqos    = 4'd0;
  assign m_axi_awregion = 4'd0;

  assign m_axi_wvalid = (state == ST_W) && s_write_data_valid;
  assign m_axi_wdata  = s_write_data;
  assign m_axi_wstrb  = {STRB_W{1'b1}};
  assign m_axi_wlast  = (state == ST_W) && (beat_cnt == len_q - 9'd1);
  assign m_axi_bready = (state == ST_B);
  assign w_idle       = (state == ST_IDLE);

  assign addr_hs   = s_write_addr_valid && s_write_addr_ready;
  assign count_hs  = s_write_count_valid && s_write_count_ready;
  assign w_hs      = m_axi_wvalid && m_axi_wready;
  assign last_beat = w_hs && m_axi_wlast;
  assign b_hs      = m_axi_bvalid && m_axi_bready;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:       if (addr_hs) state_nxt = ST_WAIT_COUNT;
      ST_WAIT_COUNT: if (count_hs) state_nxt = (s_write_count == '0) ? ST_IDLE : ST_CALC;
      ST_CALC:       state_nxt = ST_AW;
      ST_AW:         if (m_axi_awready) state_nxt = ST_W;
      ST_W:          if (last_beat) state_nxt = ST_B;
      ST_B:          if (b_hs) state_nxt = (remaining != COUNT_WIDTH'(len_q)) ? ST_CALC : ST_IDLE;
      default:       state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge host_clk or negedge host_rst_n) begin
    if (!host_rst_n) begin
      state     <= ST_IDLE;
      rst_done  <= 1'b0;
      w_err     <= 1'b0;
      remaining <= '0;
      beat_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      rst_done <= 1'b1;
      if (addr_hs)
        w_err <= 1'b0;
      else if (b_hs && (m_axi_bresp != RESP_OKAY))
        w_err <= 1'b1;
      if (count_hs)
        remaining <= s_write_count;
      else if (b_hs)
        remaining <= remaining - COUNT_WIDTH'(len_q);
      if (last_beat)
        beat_cnt <= '0;
      else if (w_hs)
        beat_cnt <= beat_cnt + 9'd1;
    end
  end

  // Address and burst length carry no reset; they are only observed once loaded.
  always_ff @(posedge host_clk) begin
    if (addr_hs)
      addr_q <= s_write_addr & ~ADDR_WIDTH'(STRB_W - 1);
    else if (b_hs)
      addr_q <= addr_q + (ADDR_WIDTH'(len_q) << SIZE);
    if (state == ST_CALC) begin
      len_q   <= len_calc;
      awlen_q <= 8'(len_calc - 9'd1);
    end
  end

endmodule

// File: tb/tb_emulib_dma_burst_writer.sv
// Directed bench with an AXI slave model and a scoreboard of expected bursts and data beats.
`timescale 1ns/1ps
module tb_emulib_dma_burst_writer;

  logic        host_clk = 1'b0;
  logic        host_rst_n = 1'b0;
  logic        s_write_addr_valid = 1'b0, s_write_addr_ready;
  logic [31:0] s_write_addr = '0;
  logic        s_write_count_valid = 1'b0, s_write_count_ready;
  logic [15:0] s_write_count = '0;
  logic        s_write_data_valid = 1'b0, s_write_data_ready;
  logic [63:0] s_write_data = '0;
  logic        m_axi_awvalid, m_axi_awready = 1'b0;
  logic [31:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize, m_axi_awprot;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awlock;
  logic [3:0]  m_axi_awcache, m_axi_awqos, m_axi_awregion;
  logic        m_axi_wvalid, m_axi_wready = 1'b0, m_axi_wlast;
  logic [63:0] m_axi_wdata;
  logic [7:0]  m_axi_wstrb;
  logic        m_axi_bvalid = 1'b0, m_axi_bready;
  logic [1:0]  m_axi_bresp = 2'b00;
  logic        w_idle, w_err;

  always #5 host_clk = ~host_clk;

  emulib_dma_burst_writer dut (
    .host_clk(host_clk), .host_rst_n(host_rst_n),
    .s_write_addr_valid(s_write_addr_valid), .s_write_addr_ready(s_write_addr_ready),
    .s_write_addr(s_write_addr),
    .s_write_count_valid(s_write_count_valid), .s_write_count_ready(s_write_count_ready),
    .s_write_count(s_write_count),
    .s_write_data_valid(s_write_data_valid), .s_write_data_ready(s_write_data_ready),
    .s_write_data(s_write_data),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_awaddr(m_axi_awaddr),
    .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_awlock(m_axi_awlock), .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
    .m_axi_awqos(m_axi_awqos), .m_axi_awregion(m_axi_awregion),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_wdata(m_axi_wdata),
    .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bresp(m_axi_bresp), .m_axi_bready(m_axi_bready),
    .w_idle(w_idle), .w_err(w_err)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [8:0]  len;
  } aw_t;

  int          checks = 0;
  int          failures = 0;
  aw_t         exp_aw[$];
  logic [63:0] exp_d[$];
  logic [63:0] src_q[$];
  bit          stall = 0, src_taken = 0, b_taken = 0, b_pend = 0, aw_wait = 0;
  int          b_idx = 0, err_idx = -1, cur_beat = 0, cur_len = 0;
  logic [31:0] aw_wait_addr = '0;
  aw_t         mon_e;
  logic [63:0] mon_d;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slave and data-source model: drive on the falling edge, judge handshakes 1 ns later.
  always @(negedge host_clk) begin
    if (src_taken) begin
      if (src_q.size() > 0) mon_d = src_q.pop_front();
      s_write_data_valid = 1'b0;
      src_taken = 0;
    end
    if (b_taken) begin
      m_axi_bvalid = 1'b0;
      b_taken = 0;
    end
    m_axi_awready = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
    m_axi_wready  = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
    if (!s_write_data_valid && src_q.size() > 0 && (!stall || $urandom_range(0, 2) != 0)) begin
      s_write_data_valid = 1'b1;
      s_write_data = src_q[0];
    end
    if (b_pend && !m_axi_bvalid && (!stall || $urandom_range(0, 1) == 1)) begin
      m_axi_bvalid = 1'b1;
      m_axi_bresp = (b_idx == err_idx) ? 2'b10 : 2'b00;
      b_pend = 0;
    end
    #1;
    if (host_rst_n) begin
      if (aw_wait) begin
        chk("aw_hold_valid", m_axi_awvalid, 1);
        chk("aw_hold_addr", m_axi_awaddr, aw_wait_addr);
      end
      aw_wait = m_axi_awvalid && !m_axi_awready;
      aw_wait_addr = m_axi_awaddr;
      if (m_axi_awvalid && m_axi_awready) begin
        chk("aw_while_busy", (cur_len != 0) || b_pend || m_axi_bvalid, 0);
        if (exp_aw.size() == 0) chk("aw_unexpected", 1, 0);
        else begin
          mon_e = exp_aw.pop_front();
          chk("awaddr", m_axi_awaddr, mon_e.addr);
          chk("awlen", m_axi_awlen, mon_e.len - 9'd1);
        end
        chk("aw_4k", (int'(m_axi_awaddr[11:0]) + (int'(m_axi_awlen) + 1) * 8) <= 4096, 1);
        chk("awsize_burst", {m_axi_awsize, m_axi_awburst}, {3'd3, 2'b01});
        chk("aw_const", {m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awregion}, 0);
        cur_len = int'(m_axi_awlen) + 1;
        cur_beat = 0;
      end
      if (m_axi_wvalid && m_axi_wready) begin
        if (cur_len == 0) chk("w_before_aw", 1, 0);
        else begin
          chk("wlast", m_axi_wlast, cur_beat == cur_len - 1);
          chk("wstrb", m_axi_wstrb, 8'hff);
          if (exp_d.size() == 0) chk("w_unexpected", 1, 0);
          else chk("wdata", m_axi_wdata, exp_d.pop_front());
          src_taken = 1;
          cur_beat++;
          if (cur_beat == cur_len) begin
            cur_len = 0;
            b_pend = 1;
          end
        end
      end
      if (m_axi_bvalid && m_axi_bready) begin
        b_taken = 1;
        b_idx++;
      end
    end
  end

  task automatic plan(input logic [31:0] addr, input int count);
    logic [31:0] a;
    int rem, btb, len;
    aw_t e;
    logic [63:0] d;
    a = addr & ~32'h7;
    rem = count;
    while (rem > 0) begin
      btb = (4096 - int'(a[11:0])) / 8;
      len = (rem < 16) ? rem : 16;
      if (btb < len) len = btb;
      e.addr = a;
      e.len = 9'(len);
      exp_aw.push_back(e);
      a = a + 32'(len * 8);
      rem = rem - len;
    end
    for (int i = 0; i < count; i++) begin
      d = {$urandom, $urandom};
      exp_d.push_back(d);
      src_q.push_back(d);
    end
    b_idx = 0;
  endtask

  task automatic send_addr(input logic [31:0] a, input bit with_count, input logic [15:0] c);
    int n = 0;
    s_write_addr = a;
    s_write_addr_valid = 1'b1;
    if (with_count) begin
      s_write_count = c;
      s_write_count_valid = 1'b1;
    end
    while (!s_write_addr_ready && n < 50) begin
      @(posedge host_clk); #1; n++;
    end
    chk("addr_hs_timeout", n >= 50, 0);
    if (with_count) chk("count_ready_in_idle", s_write_count_ready, 0);
    @(posedge host_clk); #1;
    s_write_addr_valid = 1'b0;
  endtask

  task automatic send_count(input logic [15:0] c);
    int n = 0;
    s_write_count = c;
    s_write_count_valid = 1'b1;
    while (!s_write_count_ready && n < 50) begin
      @(posedge host_clk); #1; n++;
    end
    chk("count_hs_timeout", n >= 50, 0);
    @(posedge host_clk); #1;
    s_write_count_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!(w_idle && exp_aw.size() == 0 && exp_d.size() == 0) && n < 3000) begin
      @(posedge host_clk); #1; n++;
    end
    chk({tag, "_timeout"}, n >= 3000, 0);
    chk({tag, "_aw_left"}, exp_aw.size(), 0);
    chk({tag, "_d_left"}, exp_d.size(), 0);
    chk({tag, "_idle"}, w_idle, 1);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge host_clk);
    #1;
    chk("rst_addr_ready", s_write_addr_ready, 0);
    chk("rst_count_ready", s_write_count_ready, 0);
    chk("rst_data_ready", s_write_data_ready, 0);
    chk("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 0);
    chk("rst_idle", w_idle, 1);
    chk("rst_err", w_err, 0);
    host_rst_n = 1'b1;
    #1;
    chk("addr_ready_before_edge", s_write_addr_ready, 0);
    @(posedge host_clk); #1;
    chk("addr_ready_after_rst", s_write_addr_ready, 1);

    // 40 beats from 0: three bursts, 2-cycle count-to-awvalid latency.
    plan(32'h0, 40);
    send_addr(32'h0, 0, 16'd0);
    send_count(16'd40);
    chk("aw_lat_calc", m_axi_awvalid, 0);
    chk("data_ready_calc", s_write_data_ready, 0);
    @(posedge host_clk); #1;
    chk("aw_lat_aw", m_axi_awvalid, 1);
    wait_done("t1");

    // 4 KiB split, address and count offered together.
    plan(32'hFE0, 10);
    send_addr(32'hFE0, 1, 16'd10);
    send_count(16'd10);
    wait_done("t2");

    // Zero count: no traffic, idle again on the second cycle.
    send_addr(32'h500, 0, 16'd0);
    chk("zero_busy", w_idle, 0);
    send_count(16'd0);
    chk("zero_idle", w_idle, 1);
    repeat (5) @(posedge host_clk);
    #1;
    chk("zero_no_aw", m_axi_awvalid, 0);

    // Random stalls everywhere, 100 beats crossing a page.
    stall = 1;
    plan(32'h1F40, 100);
    send_addr(32'h1F40, 0, 16'd0);
    send_count(16'd100);
    wait_done("t4");
    stall = 0;

    // SLVERR on the second of three bursts.
    err_idx = 1;
    plan(32'h3000, 40);
    send_addr(32'h3000, 0, 16'd0);
    send_count(16'd40);
    wait_done("t5");
    chk("w_err_set", w_err, 1);
    err_idx = -1;
    plan(32'h4000, 8);
    send_addr(32'h4000, 0, 16'd0);
    chk("w_err_clear", w_err, 0);
    send_count(16'd8);
    wait_done("t5b");
    chk("w_err_stays_clear", w_err, 0);

    // Reset during a W beat, then a fresh transfer.
    plan(32'h5000, 40);
    send_addr(32'h5000, 0, 16'd0);
    send_count(16'd40);
    n = 0;
    while (!(m_axi_wvalid && m_axi_wready) && n < 100) begin
      @(posedge host_clk); #1; n++;
    end
    chk("mid_w_timeout", n >= 100, 0);
    host_rst_n = 1'b0;
    exp_aw.delete();
    exp_d.delete();
    src_q.delete();
    s_write_data_valid = 1'b0;
    m_axi_bvalid = 1'b0;
    b_pend = 0; src_taken = 0; b_taken = 0; aw_wait = 0;
    cur_len = 0; cur_beat = 0;
    @(posedge host_clk); #1;
    chk("midrst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 0);
    chk("midrst_idle", w_idle, 1);
    chk("midrst_readies", {s_write_addr_ready, s_write_data_ready}, 0);
    host_rst_n = 1'b1;
    @(posedge host_clk); #1;
    plan(32'h6008, 20);
    send_addr(32'h6008, 0, 16'd0);
    send_count(16'd20);
    wait_done("t7");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
